front_panel_ctrl: RTL and testbench

FRONT_PANEL_CTRL -- requirements
Module: front_panel_ctrl

---
 rtl/jala_panel_pkg.sv | 17 +
 rtl/front_panel_ctrl_debouncer.sv | 54 +++++
 rtl/front_panel_ctrl.sv | 113 +++++++++++
 tb/tb_front_panel_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jala_panel_pkg.sv
// Front panel shared types and defaults.
// FSM states, switch bit map, parameter defaults.
package jala_panel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_RUNNING,
    ST_HALTED,
    ST_RSTPULSE
  } panel_state_e;

  localparam int RUN_MODE_BIT = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_RST_PULSE_CYCLES = 4;

endpackage

// File: rtl/front_panel_ctrl_debouncer.sv
// Two-flop synchronizer followed by a
// stability counter and clean register.
module debouncer
  import jala_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;

  // Count consecutive disagreeing cycles; adopt the
  // synced value once the count is complete.
  always_comb begin
    sync_d  = {sync_q[0], din};
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync_q[1] == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign dout = clean_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// Front panel: debounced buttons/switches and
// run / step / halt / reset-pulse control FSM.
module front_panel_ctrl
  import jala_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       s_button,
  input  logic       w_button,
  input  logic [3:0] switches,
  input  logic       endProgram,
  output logic       run,
  output logic       CtrlRst,
  output logic [3:0] switches_clean,
  output logic       halted
);

  localparam int PW =
    (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PCNT_MAX =
    PW'(RST_PULSE_CYCLES - 1);

  logic [5:0] raw;
  logic [5:0] clean;

  assign raw = {switches, w_button, s_button};

  for (genvar i = 0; i < 6; i++) begin : g_deb
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk (CLK),
      .rst (RESET),
      .din (raw[i]),
      .dout(clean[i])
    );
  end

  assign switches_clean = clean[5:2];

  logic [1:0]    btn_prev_q, btn_prev_d;
  logic          s_rise, w_rise, run_mode;
  panel_state_e  state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;

  assign s_rise   = clean[0] & ~btn_prev_q[0];
  assign w_rise   = clean[1] & ~btn_prev_q[1];
  assign run_mode = clean[2+RUN_MODE_BIT];

  // Next state, pulse count and Moore outputs;
  // a reset press overrides everything else.
  always_comb begin
    btn_prev_d = clean[1:0];
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    run        = 1'b0;
    CtrlRst    = 1'b0;
    halted     = 1'b0;
    if (w_rise) begin
      state_d = ST_RSTPULSE;
      pcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (s_rise)
            state_d = run_mode ? ST_RUNNING : ST_STEP;
        end
        ST_STEP: begin
          state_d = endProgram ? ST_HALTED : ST_IDLE;
        end
        ST_RUNNING: begin
          if (endProgram)
            state_d = ST_HALTED;
          else if (s_rise)
            state_d = ST_IDLE;
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        ST_RSTPULSE: begin
          if (pcnt_q == PCNT_MAX) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    run     = (state_q == ST_STEP) ||
              (state_q == ST_RUNNING);
    CtrlRst = (state_q == ST_RSTPULSE);
    halted  = (state_q == ST_HALTED);
  end

  // FSM, pulse counter and edge-detect registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      btn_prev_q <= btn_prev_d;
    end
  end

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Directed self-checking bench for front_panel_ctrl
// with short debounce and reset-pulse lengths.
module tb_front_panel_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       s_button = 1'b0;
  logic       w_button = 1'b0;
  logic [3:0] switches = 4'h0;
  logic       endProgram = 1'b0;
  logic       run, CtrlRst, halted;
  logic [3:0] switches_clean;

  int n_chk = 0;
  int n_fail = 0;

  logic run_h [0:63];
  logic rst_h [0:63];
  logic hlt_h [0:63];

  typedef struct {
    logic [3:0] sw;
    logic       endp;
    int         hold;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [7];

  front_panel_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .RST_PULSE_CYCLES(3)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .s_button      (s_button),
    .w_button      (w_button),
    .switches      (switches),
    .endProgram    (endProgram),
    .run           (run),
    .CtrlRst       (CtrlRst),
    .switches_clean(switches_clean),
    .halted        (halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic window(input int n, input int rel,
                        input logic ps, input logic pw);
    @(negedge CLK);
    if (ps) s_button = 1'b1;
    if (pw) w_button = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK);
      #1;
      run_h[k] = run;
      rst_h[k] = CtrlRst;
      hlt_h[k] = halted;
      if (k == rel) begin
        @(negedge CLK);
        s_button = 1'b0;
        w_button = 1'b0;
      end
    end
  endtask

  function automatic int cnt1(input int which, input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) begin
      if (which == 0 && run_h[k]) c++;
      if (which == 1 && rst_h[k]) c++;
      if (which == 2 && hlt_h[k]) c++;
    end
    return c;
  endfunction

  function automatic int first1(input int which, input int n);
    for (int k = 1; k <= n; k++) begin
      if (which == 0 && run_h[k]) return k;
      if (which == 1 && rst_h[k]) return k;
    end
    return 0;
  endfunction

  task automatic set_sw(input logic [3:0] v);
    @(negedge CLK);
    switches = v;
    repeat (8) @(posedge CLK);
    #1;
    chk("sw_settle", int'(switches_clean), int'(v));
  endtask

  initial begin
    int acc;

    tbl[0] = '{4'b0101, 1'b0, 8, 4'b0101};
    tbl[1] = '{4'b1010, 1'b1, 8, 4'b1010};
    tbl[2] = '{4'b1111, 1'b0, 5, 4'b1010};
    tbl[3] = '{4'b1111, 1'b0, 1, 4'b1111};
    tbl[4] = '{4'b0000, 1'b1, 2, 4'b1111};
    tbl[5] = '{4'b1111, 1'b0, 8, 4'b1111};
    tbl[6] = '{4'b0000, 1'b0, 8, 4'b0000};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_run", int'(run), 0);
    chk("rst_ctrlrst", int'(CtrlRst), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_sw", int'(switches_clean), 0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      switches   = tbl[i].sw;
      endProgram = tbl[i].endp;
      repeat (tbl[i].hold) @(posedge CLK);
      #1;
      chk($sformatf("tbl%0d_sw", i),
          int'(switches_clean), int'(tbl[i].exp));
      chk($sformatf("tbl%0d_run", i), int'(run), 0);
      chk($sformatf("tbl%0d_halt", i), int'(halted), 0);
    end
    @(negedge CLK);
    endProgram = 1'b0;

    acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (i < 20 && i % 2 == 0) s_button = ~s_button;
      @(posedge CLK);
      #1;
      if (run) acc++;
    end
    chk("bounce_run_cycles", acc, 0);

    window(20, 10, 1'b1, 1'b0);
    chk("step_first", first1(0, 20), 7);
    chk("step_count", cnt1(0, 20), 1);
    chk("step_nohalt", cnt1(2, 20), 0);

    set_sw(4'b1000);
    window(20, 10, 1'b1, 1'b0);
    chk("runm_first", first1(0, 20), 7);
    chk("runm_count", cnt1(0, 20), 14);

    @(negedge CLK);
    switches = 4'b0000;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      if (run) acc++;
    end
    chk("runm_mode_change", acc, 10);

    @(negedge CLK);
    endProgram = 1'b1;
    @(posedge CLK);
    #1;
    chk("end_run", int'(run), 0);
    chk("end_halted", int'(halted), 1);
    @(negedge CLK);
    endProgram = 1'b0;

    window(20, 10, 1'b1, 1'b0);
    chk("halt_ignore_run", cnt1(0, 20), 0);
    chk("halt_stays", cnt1(2, 20), 20);

    window(20, 10, 1'b0, 1'b1);
    chk("wrst_first", first1(1, 20), 7);
    chk("wrst_count", cnt1(1, 20), 3);
    chk("wrst_halt_before", int'(hlt_h[6]), 1);
    chk("wrst_halt_during", int'(hlt_h[7]), 0);
    chk("wrst_halt_after", int'(hlt_h[20]), 0);
    chk("wrst_run", cnt1(0, 20), 0);

    set_sw(4'b0110);
    window(20, 10, 1'b1, 1'b1);
    chk("both_run", cnt1(0, 20), 0);
    chk("both_rst_count", cnt1(1, 20), 3);
    chk("both_rst_first", first1(1, 20), 7);

    @(negedge CLK);
    w_button = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("mid_pulse_high", int'(CtrlRst), 1);
    @(negedge CLK);
    RESET = 1'b1;
    w_button = 1'b0;
    @(posedge CLK);
    #1;
    chk("mid_rst_ctrlrst", int'(CtrlRst), 0);
    chk("mid_rst_run", int'(run), 0);
    chk("mid_rst_halted", int'(halted), 0);
    chk("mid_rst_sw", int'(switches_clean), 0);
    @(negedge CLK);
    RESET = 1'b0;
    acc = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK);
      #1;
      if (CtrlRst || run) acc++;
    end
    chk("post_rst_quiet", acc, 0);
    chk("post_rst_sw", int'(switches_clean), 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
